llr_frame_buffer: RTL and testbench

Parametrised LLR input assembler in front of the min-sum decoder layers. Collects N_LLRS channel LLRs per beat into full N_V-LLR codeword frames. Holds up to N_BUF assembled frames (N_BUF=2 ping-pong) so the next codeword streams in while the decoder consumes the current one. Adds frame-sync checking via first_data and a valid/ready output handshake.

---
 rtl/llr_frame_buffer.sv | 124 ++++++++++++
 tb/tb_llr_frame_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_frame_buffer.sv
// llr_frame_buffer: assembles N_LLRS-wide LLR beats into N_V-LLR codeword
// frames and holds up to N_BUF complete frames for the min-sum decoder.
//
// Handshakes (both sides):
//   Input side: a beat transfers on a rising edge where data_valid && data_ready.
//   data_ready is registered. It never depends on data_valid in the same cycle.
//   Output side: a frame transfers on a rising edge where frame_valid && frame_ready.
//   frame_out stays stable from the cycle frame_valid rises until that transfer.
//   No output has a combinational path from any input.
module llr_frame_buffer #(
  parameter int WIDTH  = 8,
  parameter int N_LLRS = 4,
  parameter int N_V    = 31,
  parameter int N_BUF  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_LLRS*WIDTH-1:0]      llr,
  input  logic                         first_data,
  input  logic                         data_valid,
  output logic                         data_ready,
  output logic [N_V*WIDTH-1:0]         frame_out,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         frame_err,
  output logic [$clog2(N_BUF+1)-1:0]   buf_count
);

  // The last beat of a frame may be only partly used. Lanes past N_V are
  // never written because each LLR index selects its own beat and lane.
  localparam int BEATS = (N_V + N_LLRS - 1) / N_LLRS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (N_BUF > 1) ? $clog2(N_BUF) : 1;
  localparam int NW    = $clog2(N_BUF + 1);
  localparam int FW    = N_V * WIDTH;

  logic [CW-1:0] beat_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [FW-1:0] buf_mem [N_BUF];

  logic          accept;
  logic          consume;
  logic          restart;
  logic          drop;
  logic          store;
  logic          complete;
  logic [CW-1:0] wr_beat;
  logic [NW-1:0] buf_count_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_BUF - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode the accepted beat against the frame-sync rules.
  always_comb begin
    accept   = data_valid && data_ready;
    consume  = frame_valid && frame_ready;
    // first_data always restarts at beat 0. A restart mid-frame discards the
    // partial frame but keeps the same write buffer.
    restart  = accept && first_data && (beat_cnt != '0);
    // A continuation beat with no frame in progress has no position to go to.
    drop     = accept && !first_data && (beat_cnt == '0);
    store    = accept && !drop;
    wr_beat  = first_data ? '0 : beat_cnt;
    complete = store && (wr_beat == CW'(BEATS - 1));
  end

  // Occupancy after this edge: completion and consumption cancel out.
  always_comb begin
    buf_count_next = buf_count;
    if (complete && !consume) begin
      buf_count_next = buf_count + 1'b1;
    end else if (!complete && consume) begin
      buf_count_next = buf_count - 1'b1;
    end
  end

  assign frame_valid = (buf_count != '0);
  // When buf_count > 0, rd_ptr never points to the buffer being filled, so
  // frame_out cannot change while a frame waits for frame_ready.
  assign frame_out   = buf_mem[rd_ptr];

  // Control state: beat position, ping-pong pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      buf_count  <= '0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err  <= restart || drop;
      buf_count  <= buf_count_next;
      data_ready <= (buf_count_next < NW'(N_BUF));
      if (store) begin
        beat_cnt <= complete ? '0 : wr_beat + 1'b1;
      end
      if (complete) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (consume) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Frame storage: write each LLR whose home beat matches the stored beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < N_BUF; b++) begin
        buf_mem[b] <= '0;
      end
    end else if (store) begin
      for (int i = 0; i < N_V; i++) begin
        if (wr_beat == CW'(i / N_LLRS)) begin
          buf_mem[wr_ptr][i*WIDTH +: WIDTH] <= llr[(i % N_LLRS)*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_llr_frame_buffer.sv
// tb_llr_frame_buffer: scoreboard bench for llr_frame_buffer.
// Expected frames are built from the driven beats and queued on completion.
// They are popped when the DUT hands a frame downstream.
module tb_llr_frame_buffer;

  localparam int WIDTH  = 8;
  localparam int N_LLRS = 4;
  localparam int N_V    = 31;
  localparam int N_BUF  = 2;
  localparam int BEATS  = (N_V + N_LLRS - 1) / N_LLRS;
  localparam int LW     = N_LLRS * WIDTH;
  localparam int FW     = N_V * WIDTH;
  localparam int NW     = $clog2(N_BUF + 1);

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] llr;
  logic          first_data;
  logic          data_valid;
  logic          data_ready;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          frame_ready;
  logic          frame_err;
  logic [NW-1:0] buf_count;

  always #5 clk = ~clk;

  llr_frame_buffer #(
    .WIDTH (WIDTH),
    .N_LLRS(N_LLRS),
    .N_V   (N_V),
    .N_BUF (N_BUF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .llr        (llr),
    .first_data (first_data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_err  (frame_err),
    .buf_count  (buf_count)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [FW-1:0] exp_q[$];
  int            m_cnt;
  logic [FW-1:0] m_frame;
  bit            last_done;
  bit            stream_mode;

  task automatic check_eq(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model for one accepted beat.
  task automatic model_accept(input bit first, input logic [LW-1:0] beat,
                              output bit exp_err, output bit done);
    exp_err = 1'b0;
    done    = 1'b0;
    if (first && m_cnt != 0) begin
      exp_err = 1'b1;
      m_cnt   = 0;
    end else if (first) begin
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      exp_err = 1'b1;
      return;
    end
    for (int j = 0; j < N_LLRS; j++) begin
      if (m_cnt * N_LLRS + j < N_V) begin
        m_frame[(m_cnt*N_LLRS + j)*WIDTH +: WIDTH] = beat[j*WIDTH +: WIDTH];
      end
    end
    m_cnt++;
    if (m_cnt == BEATS) begin
      exp_q.push_back(m_frame);
      m_cnt = 0;
      done  = 1'b1;
    end
  endtask

  function automatic logic [LW-1:0] make_beat(input int k, input bit idx_mode);
    logic [LW-1:0] b;
    for (int j = 0; j < N_LLRS; j++) begin
      if (idx_mode) begin
        b[j*WIDTH +: WIDTH] = (k*N_LLRS + j < N_V) ? WIDTH'(k*N_LLRS + j) : {WIDTH{1'b1}};
      end else begin
        b[j*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
      end
    end
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input bit first, input logic [LW-1:0] beat);
    int waited;
    bit ok;
    bit exp_err;
    bit done;
    llr        = beat;
    first_data = first;
    data_valid = 1'b1;
    waited     = 0;
    ok         = 1'b0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (data_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      check_eq("ready_timeout", data_ready, 1);
      data_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    model_accept(first, beat, exp_err, done);
    last_done = done;
    check_eq("frame_err", frame_err, exp_err);
    if (stream_mode) begin
      check_eq("stream_wait", waited, 0);
      check_eq("stream_ready", data_ready, 1);
      check_eq("stream_valid", frame_valid, done);
    end
  endtask

  task automatic send_frame(input bit idx_mode);
    for (int k = 0; k < BEATS; k++) begin
      send_beat(k == 0, make_beat(k, idx_mode));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    frame_ready = 1'b1;
    while (buf_count != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", buf_count, 0);
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst && frame_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("frame_expected", frame_valid, 0);
      end else if (frame_ready) begin
        check_eq("frame_out", frame_out, exp_q.pop_front());
      end else begin
        check_eq("frame_hold", frame_out, exp_q[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b0;
    llr         = '0;
    first_data  = 1'b0;
    data_valid  = 1'b0;
    frame_ready = 1'b0;
    m_cnt       = 0;
    m_frame     = '0;
    last_done   = 1'b0;
    stream_mode = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data_ready", data_ready, 0);
    check_eq("rst_frame_valid", frame_valid, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_buf_count", buf_count, 0);
    check_eq("rst_frame_out", frame_out, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", data_ready, 1);

    // Index-valued frame. The unused last lane carries 0xFF and must not appear.
    send_frame(1'b1);
    check_eq("t1_valid", frame_valid, 1);
    check_eq("t1_llr0", frame_out[0 +: WIDTH], 0);
    check_eq("t1_llr30", frame_out[30*WIDTH +: WIDTH], 30);
    drain();

    // Three back-to-back frames with frame_ready held high.
    frame_ready = 1'b1;
    stream_mode = 1'b1;
    repeat (3) send_frame(1'b0);
    stream_mode = 1'b0;
    drain();

    // Back-pressure: two frames fill both buffers, and the third stalls.
    frame_ready = 1'b0;
    send_frame(1'b0);
    send_frame(1'b0);
    check_eq("full_count", buf_count, 2);
    check_eq("full_ready", data_ready, 0);
    fork
      send_frame(1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        check_eq("stall_count", buf_count, 2);
        check_eq("stall_ready", data_ready, 0);
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        check_eq("one_consume_count", buf_count, 1);
        check_eq("ready_returns", data_ready, 1);
      end
    join
    check_eq("third_held", buf_count, 2);
    drain();

    // first_data arrives at beat 5. The partial frame is discarded.
    for (int k = 0; k < 5; k++) send_beat(k == 0, make_beat(k, 1'b0));
    send_beat(1'b1, make_beat(0, 1'b0));
    check_eq("resync_err", frame_err, 1);
    check_eq("resync_count", buf_count, 0);
    for (int k = 1; k < BEATS; k++) send_beat(1'b0, make_beat(k, 1'b0));
    drain();

    // Stray continuation beat while idle.
    send_beat(1'b0, make_beat(3, 1'b0));
    check_eq("idle_drop_count", buf_count, 0);
    @(posedge clk);
    #1;
    check_eq("err_pulse_end", frame_err, 0);

    // Reset at beat 4 of frame 2 while frame 1 is pending.
    frame_ready = 1'b0;
    send_frame(1'b0);
    for (int k = 0; k < 4; k++) send_beat(k == 0, make_beat(k, 1'b0));
    #2;
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    #1;
    check_eq("async_frame_valid", frame_valid, 0);
    check_eq("async_frame_out", frame_out, 0);
    check_eq("async_frame_err", frame_err, 0);
    check_eq("async_data_ready", data_ready, 0);
    check_eq("async_buf_count", buf_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_eq("release_ready_low", data_ready, 0);
    @(posedge clk);
    #1;
    check_eq("release_ready_high", data_ready, 1);
    frame_ready = 1'b1;
    send_frame(1'b1);
    drain();

    check_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
